// File: rtl/apb_timer_slave_if.sv
// apb_timer_slave_if: APB slave with wait states, byte-strobed register bank and read-only status word.
// Optional parity checking/generation is enabled by defining APB_SLV_PARITY_EN.
module apb_timer_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 4,
  parameter int WAIT_STATES = 0,
  localparam int STRB = DATA_WIDTH / 8
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_WIDTH-1:0]        PADDR,
  input  logic [DATA_WIDTH-1:0]        PWDATA,
  input  logic [STRB-1:0]              PSTRB,
  input  logic [STRB-1:0]              PADDRCHK,
  input  logic [STRB-1:0]              PWDATACHK,
  input  logic                         PSTRBCHK,
  input  logic [DATA_WIDTH-1:0]        hw_status,
  output logic [DATA_WIDTH-1:0]        PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [STRB-1:0]              PRDATACHK,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse,
  output logic                         parity_err
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [9:0] NREG = 10'(NUM_REGS);
  state_t state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic par_err_q;
  logic [9:0] k;
  logic done, addr_err, par_mis, err, wr_en;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic unused_ok;
  assign unused_ok = ^{PADDR, PADDRCHK, PWDATACHK, PSTRBCHK};
  assign k = PADDR[11:2];
  // SETUP/ACCESS name the bus phase last sampled; the current cycle is an access cycle in either
  assign done = (state_q != IDLE) && PSEL && (wait_cnt_q == 4'd0);
  assign state_d = !PSEL ? IDLE : (state_q == IDLE || done) ? (PENABLE ? IDLE : SETUP) : ACCESS;
  assign wait_cnt_d = (state_d == SETUP) ? 4'(WAIT_STATES) : (state_d == ACCESS) ? wait_cnt_q - 4'd1 : 4'd0;
  assign addr_err = (PADDR[1:0] != 2'b00) || (k > NREG) || (PWRITE && k == NREG);
  always_comb begin
`ifdef APB_SLV_PARITY_EN
    par_mis = PWRITE & (PSTRBCHK ^ (^PSTRB));
    for (int b = 0; b < STRB; b++)
      par_mis = par_mis | (PADDRCHK[b] ^ (^PADDR[8*b +: 8])) | (PWRITE & (PWDATACHK[b] ^ (^PWDATA[8*b +: 8])));
`else
    par_mis = 1'b0;
`endif
  end
  assign err = addr_err || par_mis;
  assign wr_en = done && PWRITE && !err;
  assign PREADY = done;
  assign PSLVERR = done && err;
  always_comb begin
    rd_sel = hw_status;
    for (int i = 0; i < NUM_REGS; i++)
      if (k == 10'(i)) rd_sel = regs_q[i];
  end
  assign PRDATA = (done && !PWRITE && !err) ? rd_sel : '0;
  always_comb begin
    PRDATACHK = '0;
`ifdef APB_SLV_PARITY_EN
    for (int b = 0; b < STRB; b++) PRDATACHK[b] = ^PRDATA[8*b +: 8];
`endif
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      wait_cnt_q <= 4'd0;
      wr_pulse_q <= '0;
      par_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      par_err_q <= done && par_mis;
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse_q[i] <= wr_en && (k == 10'(i));
        for (int b = 0; b < STRB; b++)
          if (wr_en && k == 10'(i) && PSTRB[b]) regs_q[i][8*b +: 8] <= PWDATA[8*b +: 8];
      end
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end
  assign reg_wr_pulse = wr_pulse_q;
  assign parity_err = par_err_q;
endmodule

// File: tb/tb_apb_timer_slave_if.sv
// tb_apb_timer_slave_if: directed and random checks of two slaves (0 and 3 wait states) against a transfer-level model.
module tb_apb_timer_slave_if;
`ifdef APB_SLV_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic PCLK = 1'b0, PRESETn = 1'b0, psel0 = 1'b0, psel3 = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0, hw_status = '0;
  logic [3:0] PSTRB = '0, PADDRCHK = '0, PWDATACHK = '0;
  logic PSTRBCHK = 1'b0;
  logic [31:0] rdata0, rdata3;
  logic rdy0, rdy3, err0, err3, perr0, perr3;
  logic [3:0] chk0, chk3, pulse0, pulse3;
  logic [127:0] regq0, regq3;
  logic [31:0] m [2][4];
  int total = 0, bad = 0;

  always #5 PCLK = ~PCLK;

  apb_timer_slave_if #(.WAIT_STATES(0)) u0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PADDRCHK(PADDRCHK), .PWDATACHK(PWDATACHK),
    .PSTRBCHK(PSTRBCHK), .hw_status(hw_status), .PRDATA(rdata0), .PREADY(rdy0), .PSLVERR(err0),
    .PRDATACHK(chk0), .reg_q(regq0), .reg_wr_pulse(pulse0), .parity_err(perr0));
  apb_timer_slave_if #(.WAIT_STATES(3)) u3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PADDRCHK(PADDRCHK), .PWDATACHK(PWDATACHK),
    .PSTRBCHK(PSTRBCHK), .hw_status(hw_status), .PRDATA(rdata3), .PREADY(rdy3), .PSLVERR(err3),
    .PRDATACHK(chk3), .reg_q(regq3), .reg_wr_pulse(pulse3), .parity_err(perr3));

  function automatic logic [3:0] bpar(input logic [31:0] x);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) p[b] = ^x[8*b +: 8];
    return p;
  endfunction

  function automatic logic [127:0] mpack(input int d);
    return {m[d][3], m[d][2], m[d][1], m[d][0]};
  endfunction

  task automatic model(input int d, input bit wr, input logic [31:0] a, wd, input logic [3:0] st, fl,
                       output logic [31:0] rd, output logic e, output logic [3:0] ck, output logic [3:0] pl);
    int k;
    k = int'(a[11:2]);
    e = (a[1:0] != 2'b00) || k > 4 || (wr && k == 4) || (PAR && fl != 4'h0);
    rd = '0;
    pl = '0;
    if (!e && !wr) begin
      if (k == 4) rd = hw_status;
      else rd = m[d][k];
    end
    if (!e && wr) begin
      pl = 4'b0001 << k;
      for (int b = 0; b < 4; b++) if (st[b]) m[d][k][8*b +: 8] = wd[8*b +: 8];
    end
    ck = PAR ? bpar(rd) : 4'h0;
  endtask

  task automatic drive_setup(input int d, input bit wr, input logic [31:0] a, wd, input logic [3:0] st, fl);
    psel0 = (d == 0);
    psel3 = (d == 1);
    PENABLE = 1'b0;
    PWRITE = wr;
    PADDR = a;
    PWDATA = wr ? wd : 32'h0;
    PSTRB = wr ? st : 4'h0;
    PSTRBCHK = ^PSTRB;
    PADDRCHK = bpar(a) ^ (wr ? 4'h0 : fl);
    PWDATACHK = wr ? (bpar(wd) ^ fl) : 4'h0;
  endtask

  task automatic xfer(input int d, input bit wr, input logic [31:0] a, wd, input logic [3:0] st, fl,
                      output logic [31:0] rd, output logic e, output logic [3:0] ck, output int waits);
    @(posedge PCLK); #1;
    drive_setup(d, wr, a, wd, st, fl);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = -1;
    rd = '0;
    e = 1'b0;
    ck = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if ((d == 0 ? rdy0 : rdy3) === 1'b1) begin
        waits = i;
        rd = d == 0 ? rdata0 : rdata3;
        e = d == 0 ? err0 : err3;
        ck = d == 0 ? chk0 : chk3;
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge PCLK); #1;
    psel0 = 1'b0;
    psel3 = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({rdy0, err0, rdata0, chk0, pulse0, perr0, rdy3, err3, rdata3, chk3, pulse3, perr3} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {rdy0, err0, rdata0, chk0, pulse0, perr0, rdy3, err3, rdata3, chk3, pulse3, perr3});
    end
    total++;
    if (regq0 !== '0 || regq3 !== '0) begin
      bad++;
      $display("FAIL reset_regs got=%h/%h exp=0", regq0, regq3);
    end
  endtask

  task automatic test_write_ws0();
    logic [31:0] rd, erd;
    logic e, ee;
    logic [3:0] ck, eck, epl;
    int w;
    model(0, 1, 32'h4, 32'hA5A5_1234, 4'hF, 4'h0, erd, ee, eck, epl);
    xfer(0, 1, 32'h4, 32'hA5A5_1234, 4'hF, 4'h0, rd, e, ck, w);
    total++;
    if (w != 0) begin bad++; $display("FAIL ws0_waits got=%0d exp=0", w); end
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL ws0_slverr got=%b exp=0", e); end
    idle();
    total++;
    if (regq0[63:32] !== 32'hA5A5_1234) begin bad++; $display("FAIL ws0_reg1 got=%h exp=a5a51234", regq0[63:32]); end
    total++;
    if (pulse0 !== 4'b0010) begin bad++; $display("FAIL ws0_pulse got=%b exp=0010", pulse0); end
  endtask

  task automatic test_strobe_ws3();
    logic [31:0] rd, erd;
    logic e, ee;
    logic [3:0] ck, eck, epl;
    int w;
    model(1, 1, 32'h0, 32'hFFFF_FFFF, 4'hF, 4'h0, erd, ee, eck, epl);
    xfer(1, 1, 32'h0, 32'hFFFF_FFFF, 4'hF, 4'h0, rd, e, ck, w);
    idle();
    model(1, 1, 32'h0, 32'h0000_5500, 4'b0010, 4'h0, erd, ee, eck, epl);
    xfer(1, 1, 32'h0, 32'h0000_5500, 4'b0010, 4'h0, rd, e, ck, w);
    total++;
    if (w != 3) begin bad++; $display("FAIL ws3_waits got=%0d exp=3", w); end
    idle();
    total++;
    if (regq3[31:0] !== 32'hFFFF_55FF) begin bad++; $display("FAIL ws3_strobe got=%h exp=ffff55ff", regq3[31:0]); end
    total++;
    if (pulse3 !== 4'b0001) begin bad++; $display("FAIL ws3_pulse got=%b exp=0001", pulse3); end
  endtask

  task automatic test_status();
    logic [31:0] rd, erd;
    logic e, ee;
    logic [3:0] ck, eck, epl;
    int w;
    hw_status = 32'h8000_0001;
    model(0, 0, 32'h10, 32'h0, 4'h0, 4'h0, erd, ee, eck, epl);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 4'h0, rd, e, ck, w);
    total++;
    if (rd !== 32'h8000_0001 || e !== 1'b0) begin bad++; $display("FAIL status_read got=%h/%b exp=80000001/0", rd, e); end
    total++;
    if (ck !== (PAR ? 4'b1001 : 4'b0000)) begin bad++; $display("FAIL status_chk got=%b exp=%b", ck, PAR ? 4'b1001 : 4'b0000); end
    idle();
    model(0, 1, 32'h10, 32'h1234_5678, 4'hF, 4'h0, erd, ee, eck, epl);
    xfer(0, 1, 32'h10, 32'h1234_5678, 4'hF, 4'h0, rd, e, ck, w);
    total++;
    if (e !== 1'b1) begin bad++; $display("FAIL status_write_err got=%b exp=1", e); end
    idle();
    total++;
    if (pulse0 !== 4'h0 || regq0 !== mpack(0)) begin bad++; $display("FAIL status_write_nochange got=%b/%h exp=0/%h", pulse0, regq0, mpack(0)); end
  endtask

  task automatic test_parity();
    logic [31:0] rd, erd;
    logic e, ee;
    logic [3:0] ck, eck, epl;
    int w;
    model(0, 1, 32'h8, 32'hDEAD_BEEF, 4'hF, 4'b0001, erd, ee, eck, epl);
    xfer(0, 1, 32'h8, 32'hDEAD_BEEF, 4'hF, 4'b0001, rd, e, ck, w);
    total++;
    if (e !== PAR) begin bad++; $display("FAIL parity_slverr got=%b exp=%b", e, PAR); end
    idle();
    total++;
    if (regq0[95:64] !== (PAR ? 32'h0 : 32'hDEAD_BEEF)) begin bad++; $display("FAIL parity_reg2 got=%h exp=%h", regq0[95:64], PAR ? 32'h0 : 32'hDEAD_BEEF); end
    total++;
    if (perr0 !== PAR || pulse0 !== (PAR ? 4'h0 : 4'b0100)) begin bad++; $display("FAIL parity_pulses got=%b/%b", perr0, pulse0); end
  endtask

  task automatic test_bad_addr();
    logic [31:0] rd, erd;
    logic e, ee;
    logic [3:0] ck, eck, epl;
    int w;
    xfer(1, 0, 32'h40, 32'h0, 4'h0, 4'h0, rd, e, ck, w);
    total++;
    if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL bad_addr_40 got=%b/%h exp=1/0", e, rd); end
    idle();
    xfer(1, 0, 32'h6, 32'h0, 4'h0, 4'h0, rd, e, ck, w);
    total++;
    if (e !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL bad_addr_6 got=%b/%h exp=1/0", e, rd); end
    idle();
    model(1, 1, 32'hABC0_0004, 32'h1357_9BDF, 4'hF, 4'h0, erd, ee, eck, epl);
    xfer(1, 1, 32'hABC0_0004, 32'h1357_9BDF, 4'hF, 4'h0, rd, e, ck, w);
    idle();
    xfer(1, 0, 32'h0000_0004, 32'h0, 4'h0, 4'h0, rd, e, ck, w);
    total++;
    if (e !== 1'b0 || rd !== 32'h1357_9BDF) begin bad++; $display("FAIL upper_bits_ignored got=%b/%h exp=0/13579bdf", e, rd); end
    idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd, erd;
    logic e, ee;
    logic [3:0] ck, eck, epl;
    int w;
    @(posedge PCLK); #1;
    drive_setup(1, 1, 32'hC, 32'h1111_1111, 4'hF, 4'h0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    total++;
    if (rdy3 !== 1'b0) begin bad++; $display("FAIL abort_wait_ready got=%b exp=0", rdy3); end
    idle();
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    total++;
    if (pulse3 !== 4'h0 || regq3 !== mpack(1)) begin bad++; $display("FAIL abort_nowrite got=%b/%h exp=0/%h", pulse3, regq3, mpack(1)); end
    model(1, 1, 32'hC, 32'h2222_2222, 4'hF, 4'h0, erd, ee, eck, epl);
    xfer(1, 1, 32'hC, 32'h2222_2222, 4'hF, 4'h0, rd, e, ck, w);
    total++;
    if (w != 3 || e !== 1'b0) begin bad++; $display("FAIL abort_recover got=%0d/%b exp=3/0", w, e); end
    idle();
    total++;
    if (pulse3 !== 4'b1000 || regq3 !== mpack(1)) begin bad++; $display("FAIL abort_recover_reg got=%b/%h exp=1000/%h", pulse3, regq3, mpack(1)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd;
    logic e, ee;
    logic [3:0] ck, eck, epl;
    int w;
    @(posedge PCLK); #1;
    drive_setup(1, 1, 32'h8, 32'h7777_7777, 4'hF, 4'h0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) m[d][i] = '0;
    total++;
    if ({rdy3, err3, rdata3, chk3, pulse3, perr3} !== '0) begin bad++; $display("FAIL reset_mid_outputs got=%h exp=0", {rdy3, err3, rdata3, chk3, pulse3, perr3}); end
    total++;
    if (regq3 !== '0 || regq0 !== '0) begin bad++; $display("FAIL reset_mid_regs got=%h/%h exp=0", regq3, regq0); end
    @(posedge PCLK); #1;
    psel3 = 1'b0;
    PENABLE = 1'b0;
    PRESETn = 1'b1;
    model(1, 1, 32'h8, 32'h0BAD_F00D, 4'hF, 4'h0, erd, ee, eck, epl);
    xfer(1, 1, 32'h8, 32'h0BAD_F00D, 4'hF, 4'h0, rd, e, ck, w);
    total++;
    if (w != 3 || e !== 1'b0) begin bad++; $display("FAIL reset_mid_next got=%0d/%b exp=3/0", w, e); end
    idle();
    total++;
    if (regq3 !== mpack(1)) begin bad++; $display("FAIL reset_mid_next_reg got=%h exp=%h", regq3, mpack(1)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd;
    logic e, ee;
    logic [3:0] ck, eck, epl;
    int w;
    for (int d = 0; d < 2; d++) begin
      model(d, 1, 32'h0, 32'hCAFE_0000 + d, 4'hF, 4'h0, erd, ee, eck, epl);
      xfer(d, 1, 32'h0, 32'hCAFE_0000 + d, 4'hF, 4'h0, rd, e, ck, w);
      model(d, 1, 32'h4, 32'hBEEF_0000 + d, 4'hF, 4'h0, erd, ee, eck, epl);
      xfer(d, 1, 32'h4, 32'hBEEF_0000 + d, 4'hF, 4'h0, rd, e, ck, w);
      total++;
      if (w != (d ? 3 : 0) || e !== 1'b0) begin bad++; $display("FAIL b2b_write%0d got=%0d/%b", d, w, e); end
      model(d, 0, 32'h0, 32'h0, 4'h0, 4'h0, erd, ee, eck, epl);
      xfer(d, 0, 32'h0, 32'h0, 4'h0, 4'h0, rd, e, ck, w);
      total++;
      if (w != (d ? 3 : 0) || rd !== erd) begin bad++; $display("FAIL b2b_read%0d got=%0d/%h exp=%h", d, w, rd, erd); end
      idle();
      total++;
      if ((d ? regq3 : regq0) !== mpack(d)) begin bad++; $display("FAIL b2b_regs%0d got=%h exp=%h", d, d ? regq3 : regq0, mpack(d)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, r, wd;
    logic e, ee;
    logic [3:0] ck, eck, epl, st, fl;
    logic [1:0] lo;
    logic [31:0] a;
    int w, d, k;
    bit wr;
    for (int n = 0; n < 60; n++) begin
      d = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      k = int'($urandom_range(0, 6));
      r = $urandom();
      lo = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a = {r[31:12], 10'(k), lo};
      fl = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      st = 4'($urandom());
      wd = $urandom();
      hw_status = $urandom();
      model(d, wr, a, wd, st, fl, erd, ee, eck, epl);
      xfer(d, wr, a, wd, st, fl, rd, e, ck, w);
      total++;
      if (w != (d ? 3 : 0)) begin bad++; $display("FAIL rnd%0d_waits got=%0d exp=%0d", n, w, d ? 3 : 0); end
      total++;
      if (e !== ee) begin bad++; $display("FAIL rnd%0d_slverr a=%h wr=%b got=%b exp=%b", n, a, wr, e, ee); end
      total++;
      if (rd !== erd || ck !== eck) begin bad++; $display("FAIL rnd%0d_rdata got=%h/%b exp=%h/%b", n, rd, ck, erd, eck); end
      idle();
      total++;
      if ((d ? pulse3 : pulse0) !== epl) begin bad++; $display("FAIL rnd%0d_pulse got=%b exp=%b", n, d ? pulse3 : pulse0, epl); end
      total++;
      if ((d ? perr3 : perr0) !== (PAR && fl != 4'h0)) begin bad++; $display("FAIL rnd%0d_parity_err got=%b exp=%b", n, d ? perr3 : perr0, PAR && fl != 4'h0); end
      total++;
      if ((d ? regq3 : regq0) !== mpack(d)) begin bad++; $display("FAIL rnd%0d_regs got=%h exp=%h", n, d ? regq3 : regq0, mpack(d)); end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) m[d][i] = '0;
    repeat (3) @(posedge PCLK);
    #1;
    test_reset();
    PRESETn = 1'b1;
    test_write_ws0();
    test_strobe_ws3();
    test_status();
    test_parity();
    test_bad_addr();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
